// File: rtl/sig_xy_pkg.sv
// Shared types and sizing helpers for the SIG_XY frame sequencer.
package sig_xy_pkg;

  localparam int unsigned PIXELS_PER_BEAT_DEF = 16;
  localparam int unsigned IMAGE_DIM_DEF       = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Beats needed to move one square image of dim x dim pixels.
  function automatic int unsigned beats_per_frame(input int unsigned dim,
                                                  input int unsigned ppb);
    return (dim * dim) / ppb;
  endfunction

  // Counter width able to hold 0..beats inclusive.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/sig_xy_vpipe.sv
// Valid/last shadow of the SIG_XY multiplier pipeline; advances only when enabled.
module sig_xy_vpipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic areset,
  input  logic en,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [LATENCY-1:0] valid_q;
  logic [LATENCY-1:0] last_q;

  // Shift register, frozen while the multiplier is stalled.
  always_ff @(posedge clk) begin
    if (areset) begin
      valid_q <= '0;
      last_q  <= '0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      last_q[0]  <= in_last;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_last  = last_q[LATENCY-1];

endmodule

// File: rtl/sig_xy_ctrl.sv
// Frame sequencer for the SIG_XY per-pixel multiplier stage.
// Optional stall-cycle counter enabled by defining SIG_XY_CTRL_PERF_EN.
module sig_xy_ctrl
  import sig_xy_pkg::*;
#(
  parameter int unsigned PIXELS_PER_BEAT = PIXELS_PER_BEAT_DEF,
  parameter int unsigned IMAGE_DIM       = IMAGE_DIM_DEF,
  parameter int unsigned LATENCY         = 1,
  localparam int unsigned BEATS          = beats_per_frame(IMAGE_DIM, PIXELS_PER_BEAT),
  localparam int unsigned CNT_W          = cnt_width(BEATS)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             start,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic             y_valid,
  output logic             y_ready,
  output logic             mult_stall,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] beat_cnt
`ifdef SIG_XY_CTRL_PERF_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             core_rdy;
  logic             fire;
  logic             last_beat;
  logic             start_acc;

  // Join the two input streams; a downstream stall blocks acceptance.
  assign mult_stall = m_valid & ~m_ready;
  assign core_rdy   = (state == RUN) & ~mult_stall;
  assign x_ready    = core_rdy & y_valid;
  assign y_ready    = core_rdy & x_valid;
  assign fire       = x_valid & y_valid & core_rdy;
  assign last_beat  = (cnt_q == CNT_W'(BEATS - 1));
  assign start_acc  = (state == IDLE) & start;
  assign beat_cnt   = cnt_q;

  // State register.
  always_ff @(posedge clk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (fire && last_beat) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (m_valid && m_ready && m_last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beats accepted in the current frame.
  always_ff @(posedge clk) begin
    if (areset)         cnt_q <= '0;
    else if (start_acc) cnt_q <= '0;
    else if (fire)      cnt_q <= cnt_q + CNT_W'(1);
  end

  sig_xy_vpipe #(
    .LATENCY (LATENCY)
  ) u_vpipe (
    .clk       (clk),
    .areset    (areset),
    .en        (~mult_stall),
    .in_valid  (fire),
    .in_last   (fire & last_beat),
    .out_valid (m_valid),
    .out_last  (m_last)
  );

`ifdef SIG_XY_CTRL_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of stalled cycles within the current frame.
  always_ff @(posedge clk) begin
    if (areset)                                   stall_q <= '0;
    else if (start_acc)                           stall_q <= '0;
    else if ((state != IDLE) && mult_stall && !(&stall_q)) stall_q <= stall_q + 32'(1);
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sig_xy_ctrl.sv
// Randomized bench for sig_xy_ctrl: LATENCY=1 and LATENCY=3 instances share stimulus.
module tb_sig_xy_ctrl;

  localparam int unsigned PPB   = 16;
  localparam int unsigned DIM   = 8;
  localparam int unsigned BEATS = 4;
  localparam int unsigned CW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset, start, x_valid, y_valid, m_ready;
  logic [1:0] xr, yr, ms, mv, ml, bs, dn;
  logic [CW-1:0] bc0, bc1;
  logic [31:0] sc0, sc1;

  sig_xy_ctrl #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .LATENCY(1)) u_dut1 (
    .clk(clk), .areset(areset), .start(start),
    .x_valid(x_valid), .x_ready(xr[0]), .y_valid(y_valid), .y_ready(yr[0]),
    .mult_stall(ms[0]), .m_valid(mv[0]), .m_ready(m_ready), .m_last(ml[0]),
    .busy(bs[0]), .done(dn[0]), .beat_cnt(bc0)
`ifdef SIG_XY_CTRL_PERF_EN
    , .stall_cycles(sc0)
`endif
  );

  sig_xy_ctrl #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .LATENCY(3)) u_dut3 (
    .clk(clk), .areset(areset), .start(start),
    .x_valid(x_valid), .x_ready(xr[1]), .y_valid(y_valid), .y_ready(yr[1]),
    .mult_stall(ms[1]), .m_valid(mv[1]), .m_ready(m_ready), .m_last(ml[1]),
    .busy(bs[1]), .done(dn[1]), .beat_cnt(bc1)
`ifdef SIG_XY_CTRL_PERF_EN
    , .stall_cycles(sc1)
`endif
  );

`ifndef SIG_XY_CTRL_PERF_EN
  assign sc0 = '0;
  assign sc1 = '0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame phase (0 idle, 1 run, 2 drain, 3 done),
  // beats taken, and a delay line of in-flight beats (0 none, 1 beat, 2 final beat).
  int lat[2] = '{1, 3};
  int ph[2];
  int cnt[2];
  int pipe[2][3];
  longint stl[2];
  int hs[2];
  int lasts[2];

  function automatic int head(input int k);
    return pipe[k][lat[k]-1];
  endfunction

  function automatic bit exp_stall(input int k);
    return (head(k) != 0) && !m_ready;
  endfunction

  function automatic bit exp_core(input int k);
    return (ph[k] == 1) && !exp_stall(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; cnt[k] = 0; stl[k] = 0; hs[k] = 0; lasts[k] = 0;
      for (int i = 0; i < 3; i++) pipe[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k);
    bit st_now, fire;
    int entry;
    st_now = exp_stall(k);
    fire   = x_valid && y_valid && exp_core(k);
    if (ph[k] != 0 && st_now && stl[k] < 64'hFFFF_FFFF) stl[k]++;
    entry = fire ? ((cnt[k] == BEATS - 1) ? 2 : 1) : 0;
    case (ph[k])
      0: if (start) begin ph[k] = 1; cnt[k] = 0; stl[k] = 0; end
      1: if (fire && cnt[k] == BEATS - 1) ph[k] = 2;
      2: if (head(k) == 2 && m_ready) ph[k] = 3;
      default: ph[k] = 0;
    endcase
    if (fire) cnt[k]++;
    if (!st_now) begin
      for (int i = lat[k] - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
      pipe[k][0] = entry;
    end
  endtask

  task automatic check_inst(input int k);
    string p;
    logic [31:0] bcv, scv;
    p   = $sformatf("L%0d", lat[k]);
    bcv = 32'(k == 0 ? bc0 : bc1);
    scv = (k == 0) ? sc0 : sc1;
    check({p, " x_ready"},    32'(xr[k]), 32'(exp_core(k) && y_valid));
    check({p, " y_ready"},    32'(yr[k]), 32'(exp_core(k) && x_valid));
    check({p, " mult_stall"}, 32'(ms[k]), 32'(exp_stall(k)));
    check({p, " m_valid"},    32'(mv[k]), 32'(head(k) != 0));
    check({p, " m_last"},     32'(ml[k]), 32'(head(k) == 2));
    check({p, " busy"},       32'(bs[k]), 32'(ph[k] != 0));
    check({p, " done"},       32'(dn[k]), 32'(ph[k] == 3));
    check({p, " beat_cnt"},   bcv, 32'(cnt[k]));
`ifdef SIG_XY_CTRL_PERF_EN
    check({p, " stall_cycles"}, scv, 32'(stl[k]));
`else
    if (scv != 0) check({p, " stall_unused"}, scv, 32'd0);
`endif
    // Frame-level scoreboard of DUT product handshakes.
    if (mv[k] && m_ready) begin
      hs[k]++;
      if (ml[k]) lasts[k]++;
    end
    if (dn[k]) begin
      check({p, " frame_beats"}, 32'(hs[k]), 32'(BEATS));
      check({p, " frame_last"},  32'(lasts[k]), 32'd1);
      hs[k] = 0; lasts[k] = 0;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic xv,
                      input logic yv, input logic mr);
    @(negedge clk);
    areset = rst; start = st; x_valid = xv; y_valid = yv; m_ready = mr;
    #1;
    for (int k = 0; k < 2; k++) check_inst(k);
    @(posedge clk);
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  endtask

  int hold;
  logic r_rst, r_st, r_mr;

  initial begin
    areset = 1'b1; start = 1'b0; x_valid = 1'b0; y_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state, then a full-rate frame.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Y stream toggling while X is always valid.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'(i % 2 == 0), 1'b1);

    // Downstream stall burst right after the first product appears.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset mid-frame after two fires, then a fresh frame.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

    // Randomized traffic with occasional long stalls, starts and resets.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      r_st  = ($urandom_range(0, 3) == 0);
      if (hold > 0) begin
        r_mr = 1'b0;
        hold--;
      end else if ($urandom_range(0, 19) == 0) begin
        hold = int'($urandom_range(4, 6));
        r_mr = 1'b0;
      end else begin
        r_mr = ($urandom_range(0, 4) != 0);
      end
      step(r_rst, r_st, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), r_mr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
